// File: rtl/bcd_to_bin_8bit_seq_if.sv
// Handshake and data bundle between a decimal-entry source and the BCD-to-binary converter.
interface bcd_to_bin_8bit_seq_if #(
  parameter int unsigned OUT_W = 8
);
  logic             start;
  logic [3:0]       centena_in;
  logic [3:0]       dezena_in;
  logic [3:0]       unidade_in;
  logic [OUT_W-1:0] bin_out;
  logic             overflow;
  logic             err_digit;
  logic             busy;
  logic             done;

  modport master (
    output start, centena_in, dezena_in, unidade_in,
    input  bin_out, overflow, err_digit, busy, done
  );

  modport slave (
    input  start, centena_in, dezena_in, unidade_in,
    output bin_out, overflow, err_digit, busy, done
  );
endinterface

// File: rtl/bcd_to_bin_8bit_seq.sv
// Three-digit BCD to binary converter using reverse double-dabble, one shift per clock.
// Invalid digits short-circuit straight to a one-cycle done with err_digit set.
module bcd_to_bin_8bit_seq #(
  parameter int unsigned N_SHIFT = 10,
  parameter int unsigned OUT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_to_bin_8bit_seq_if.slave    bus
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = $clog2(N_SHIFT + 1);
  localparam int unsigned SR_W  = BCD_W + N_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [N_SHIFT-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bin_out_q, bin_out_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               digit_err_c;
  logic               last_iter_c;
  logic [SR_W-1:0]    shifted_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [N_SHIFT-1:0] bin_shift_c;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // One reverse double-dabble step: shift right, then correct each BCD digit
  always_comb begin
    digit_err_c = (bus.centena_in > 4'd9) || (bus.dezena_in > 4'd9) || (bus.unidade_in > 4'd9);
    last_iter_c = (cnt_q == CNT_W'(1));
    shifted_c   = {bcd_q, bin_q} >> 1;
    bcd_adj_c   = {adj(shifted_c[SR_W-1 -: 4]),
                   adj(shifted_c[SR_W-5 -: 4]),
                   adj(shifted_c[SR_W-9 -: 4])};
    bin_shift_c = shifted_c[N_SHIFT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = digit_err_c ? S_DONE : S_CONV;
      S_CONV: if (last_iter_c) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    busy_d    = (state_d == S_CONV);
    done_d    = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (digit_err_c) begin
            bin_out_d = '0;
            ovf_d     = 1'b0;
            err_d     = 1'b1;
          end else begin
            bcd_d = {bus.centena_in, bus.dezena_in, bus.unidade_in};
            bin_d = '0;
            cnt_d = CNT_W'(N_SHIFT);
          end
        end
      end
      S_CONV: begin
        bcd_d = bcd_adj_c;
        bin_d = bin_shift_c;
        cnt_d = cnt_q - CNT_W'(1);
        // Truncation to the output width happens only here; overflow reports the dropped bits
        if (last_iter_c) begin
          bin_out_d = bin_shift_c[OUT_W-1:0];
          ovf_d     = |bin_shift_c[N_SHIFT-1:OUT_W];
          err_d     = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.err_digit = err_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
